// File: rtl/axi_st_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_st_rr_arbiter
//
// Packet-granular round-robin arbiter that multiplexes NUM_IN AXI-Stream slave
// ports onto one AXI-Stream master port. Once a slave is granted it keeps the
// grant until its tlast beat is accepted, so packets are never interleaved.
// The master side is a single registered stage (one beat deep, 1-cycle
// latency from slave accept to m_tvalid).
//
// Ports
//   clk, rst_n          single rising-edge clock, asynchronous active-low reset
//   s_tvalid/s_tready   per-slave handshake, one bit per slave
//   s_tdata .. s_tuser  per-slave payload, slave i packed at [i*W +: W]
//   s_tlast             per-slave end-of-packet marker
//   m_tvalid/m_tready   master handshake
//   m_tdata .. m_tuser  registered master payload
//   grant_idx           currently granted slave, meaningful while busy=1
//   busy                high while a slave holds the grant (LOCKED)
// -----------------------------------------------------------------------------
module axi_st_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_W     = 64,
  parameter int SYMBOL_NUM = 8,
  parameter int TID_W      = 8,
  parameter int TDEST_W    = 8,
  parameter int TUSER_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_IN-1:0]             s_tvalid,
  output logic [NUM_IN-1:0]             s_tready,
  input  logic [NUM_IN*DATA_W-1:0]      s_tdata,
  input  logic [NUM_IN*SYMBOL_NUM-1:0]  s_tstrb,
  input  logic [NUM_IN*SYMBOL_NUM-1:0]  s_tkeep,
  input  logic [NUM_IN-1:0]             s_tlast,
  input  logic [NUM_IN*TID_W-1:0]       s_tid,
  input  logic [NUM_IN*TDEST_W-1:0]     s_tdest,
  input  logic [NUM_IN*TUSER_W-1:0]     s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_W-1:0]             m_tdata,
  output logic [SYMBOL_NUM-1:0]         m_tstrb,
  output logic [SYMBOL_NUM-1:0]         m_tkeep,
  output logic                          m_tlast,
  output logic [TID_W-1:0]              m_tid,
  output logic [TDEST_W-1:0]            m_tdest,
  output logic [TUSER_W-1:0]            m_tuser,
  output logic [$clog2(NUM_IN)-1:0]     grant_idx,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_IN);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_rrPtr;
  logic [IDX_W-1:0]        r_grantIdx;

  logic                    r_mValid;
  logic [DATA_W-1:0]       r_mData;
  logic [SYMBOL_NUM-1:0]   r_mStrb;
  logic [SYMBOL_NUM-1:0]   r_mKeep;
  logic                    r_mLast;
  logic [TID_W-1:0]        r_mId;
  logic [TDEST_W-1:0]      r_mDest;
  logic [TUSER_W-1:0]      r_mUser;

  logic                    w_pickFound;
  logic [IDX_W-1:0]        w_pickIdx;
  logic                    w_slotFree;
  logic                    w_accept;
  logic                    w_selValid;
  logic                    w_selLast;
  logic [DATA_W-1:0]       w_selData;
  logic [SYMBOL_NUM-1:0]   w_selStrb;
  logic [SYMBOL_NUM-1:0]   w_selKeep;
  logic [TID_W-1:0]        w_selId;
  logic [TDEST_W-1:0]      w_selDest;
  logic [TUSER_W-1:0]      w_selUser;

  // Round-robin search starting at r_rrPtr. The loop walks offsets from the
  // farthest to the nearest so the last hit (smallest offset) wins.
  always_comb begin
    int cand;
    cand        = 0;
    w_pickFound = 1'b0;
    w_pickIdx   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      cand = int'(r_rrPtr) + k;
      if (cand >= NUM_IN) begin
        cand = cand - NUM_IN;
      end
      if (s_tvalid[cand]) begin
        w_pickFound = 1'b1;
        w_pickIdx   = IDX_W'(cand);
      end
    end
  end

  // Payload/handshake mux for the granted slave.
  always_comb begin
    w_selValid = 1'b0;
    w_selLast  = 1'b0;
    w_selData  = '0;
    w_selStrb  = '0;
    w_selKeep  = '0;
    w_selId    = '0;
    w_selDest  = '0;
    w_selUser  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grantIdx == IDX_W'(i)) begin
        w_selValid = s_tvalid[i];
        w_selLast  = s_tlast[i];
        w_selData  = s_tdata[i*DATA_W +: DATA_W];
        w_selStrb  = s_tstrb[i*SYMBOL_NUM +: SYMBOL_NUM];
        w_selKeep  = s_tkeep[i*SYMBOL_NUM +: SYMBOL_NUM];
        w_selId    = s_tid[i*TID_W +: TID_W];
        w_selDest  = s_tdest[i*TDEST_W +: TDEST_W];
        w_selUser  = s_tuser[i*TUSER_W +: TUSER_W];
      end
    end
  end

  // The output stage can take a beat when empty or when it drains this cycle.
  assign w_slotFree = !r_mValid || m_tready;
  assign w_accept   = (r_state == ST_LOCKED) && w_selValid && w_slotFree;

  // Only the granted slave ever sees tready, and only in LOCKED.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if ((r_state == ST_LOCKED) && (r_grantIdx == IDX_W'(i))) begin
        s_tready[i] = w_slotFree;
      end
    end
  end

  // Arbitration FSM: IDLE picks a requester, LOCKED holds it until tlast.
  // The pointer moves to the slot after the finished grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rrPtr    <= '0;
      r_grantIdx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pickFound) begin
            r_grantIdx <= w_pickIdx;
            r_state    <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_selLast) begin
            r_state <= ST_IDLE;
            r_rrPtr <= (r_grantIdx == IDX_W'(NUM_IN - 1)) ? '0 : r_grantIdx + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: load on accept, drain on m_tready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mValid <= 1'b0;
      r_mData  <= '0;
      r_mStrb  <= '0;
      r_mKeep  <= '0;
      r_mLast  <= 1'b0;
      r_mId    <= '0;
      r_mDest  <= '0;
      r_mUser  <= '0;
    end else if (w_accept) begin
      r_mValid <= 1'b1;
      r_mData  <= w_selData;
      r_mStrb  <= w_selStrb;
      r_mKeep  <= w_selKeep;
      r_mLast  <= w_selLast;
      r_mId    <= w_selId;
      r_mDest  <= w_selDest;
      r_mUser  <= w_selUser;
    end else if (m_tready) begin
      r_mValid <= 1'b0;
    end
  end

  assign m_tvalid  = r_mValid;
  assign m_tdata   = r_mData;
  assign m_tstrb   = r_mStrb;
  assign m_tkeep   = r_mKeep;
  assign m_tlast   = r_mLast;
  assign m_tid     = r_mId;
  assign m_tdest   = r_mDest;
  assign m_tuser   = r_mUser;
  assign grant_idx = r_grantIdx;
  assign busy      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_axi_st_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_st_rr_arbiter
//
// Bench for axi_st_rr_arbiter. Stimulus tasks queue packets per slave port and
// push the same beats into per-port expectation queues; a separate monitor
// checks every master beat against those queues, checks that packets stay
// contiguous, that payload holds while stalled, and, for directed cases, that
// packets leave in the expected port order. Every slave tags its beats with
// tid = port number so the monitor knows which queue a beat belongs to.
// -----------------------------------------------------------------------------
module tb_axi_st_rr_arbiter;

  localparam int NUM_IN     = 4;
  localparam int DATA_W     = 64;
  localparam int SYMBOL_NUM = 8;
  localparam int TID_W      = 8;
  localparam int TDEST_W    = 8;
  localparam int TUSER_W    = 8;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b1;
  logic [NUM_IN-1:0]             s_tvalid;
  logic [NUM_IN-1:0]             s_tready;
  logic [NUM_IN*DATA_W-1:0]      s_tdata;
  logic [NUM_IN*SYMBOL_NUM-1:0]  s_tstrb;
  logic [NUM_IN*SYMBOL_NUM-1:0]  s_tkeep;
  logic [NUM_IN-1:0]             s_tlast;
  logic [NUM_IN*TID_W-1:0]       s_tid;
  logic [NUM_IN*TDEST_W-1:0]     s_tdest;
  logic [NUM_IN*TUSER_W-1:0]     s_tuser;
  logic                          m_tvalid;
  logic                          m_tready;
  logic [DATA_W-1:0]             m_tdata;
  logic [SYMBOL_NUM-1:0]         m_tstrb;
  logic [SYMBOL_NUM-1:0]         m_tkeep;
  logic                          m_tlast;
  logic [TID_W-1:0]              m_tid;
  logic [TDEST_W-1:0]            m_tdest;
  logic [TUSER_W-1:0]            m_tuser;
  logic [1:0]                    grant_idx;
  logic                          busy;

  axi_st_rr_arbiter #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .SYMBOL_NUM(SYMBOL_NUM),
    .TID_W(TID_W), .TDEST_W(TDEST_W), .TUSER_W(TUSER_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  tid;
    logic [7:0]  dest;
    logic [7:0]  user;
    int          gap;
  } beat_t;

  beat_t pendQ[NUM_IN][$];
  beat_t expQ[NUM_IN][$];
  int    orderQ[$];
  int    startCyc[$];

  int passCount  = 0;
  int checkCount = 0;
  int cyc        = 0;
  int gapPct     = 0;
  int readyPct   = 100;
  int flushReq   = 0;
  int pktSeq     = 0;

  // Free-running cycle counter used to measure packet spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue one packet on a slave port and record what the master must emit.
  task automatic applyStimulus(input int port, input int len, input int gapBeat, input int gapLen,
                               input bit fixedData, input logic [63:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      if (fixedData) begin
        b.data = base + 64'(i);
      end else begin
        b.data = {8'(port), 16'(pktSeq), 8'(i), 32'($urandom())};
      end
      b.strb = 8'($urandom());
      b.keep = 8'($urandom());
      b.last = (i == len - 1);
      b.tid  = 8'(port);
      b.dest = 8'($urandom());
      b.user = 8'($urandom());
      b.gap  = (i == gapBeat) ? gapLen : 0;
      pendQ[port].push_back(b);
      expQ[port].push_back(b);
    end
    pktSeq++;
  endtask

  function automatic bit anyOutstanding();
    bit r;
    r = (orderQ.size() != 0);
    for (int p = 0; p < NUM_IN; p++) begin
      if (pendQ[p].size() != 0 || expQ[p].size() != 0) r = 1'b1;
    end
    return r;
  endfunction

  // Wait until every queued beat has come out, bounded by a cycle budget.
  task automatic waitDrain(input string name, input int maxCyc);
    int n;
    n = 0;
    while (anyOutstanding() && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 128'(anyOutstanding()), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  // Slave drivers: hold each beat until accepted, optional gaps, random m_tready.
  initial begin
    logic [NUM_IN-1:0] vld;
    logic [NUM_IN-1:0] fire;
    int gapCnt[NUM_IN];
    int flushSeen;
    vld = '0;
    fire = '0;
    flushSeen = 0;
    for (int p = 0; p < NUM_IN; p++) gapCnt[p] = 0;
    s_tvalid = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0; s_tlast = '0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (flushSeen != flushReq) begin
        flushSeen = flushReq;
        vld = '0;
        fire = '0;
        for (int p = 0; p < NUM_IN; p++) begin
          pendQ[p].delete();
          gapCnt[p] = 0;
        end
      end
      for (int p = 0; p < NUM_IN; p++) begin
        if (fire[p] && pendQ[p].size() > 0) begin
          void'(pendQ[p].pop_front());
          vld[p] = 1'b0;
          if (pendQ[p].size() > 0) gapCnt[p] = pendQ[p][0].gap;
        end
        if (!vld[p] && pendQ[p].size() > 0) begin
          if (gapCnt[p] > 0) gapCnt[p]--;
          else if (int'($urandom_range(99)) >= gapPct) vld[p] = 1'b1;
        end
        if (pendQ[p].size() > 0) begin
          s_tdata[p*DATA_W +: DATA_W]         = pendQ[p][0].data;
          s_tstrb[p*SYMBOL_NUM +: SYMBOL_NUM] = pendQ[p][0].strb;
          s_tkeep[p*SYMBOL_NUM +: SYMBOL_NUM] = pendQ[p][0].keep;
          s_tlast[p]                          = pendQ[p][0].last;
          s_tid[p*TID_W +: TID_W]             = pendQ[p][0].tid;
          s_tdest[p*TDEST_W +: TDEST_W]       = pendQ[p][0].dest;
          s_tuser[p*TUSER_W +: TUSER_W]       = pendQ[p][0].user;
        end else begin
          s_tdata[p*DATA_W +: DATA_W]         = '0;
          s_tstrb[p*SYMBOL_NUM +: SYMBOL_NUM] = '0;
          s_tkeep[p*SYMBOL_NUM +: SYMBOL_NUM] = '0;
          s_tlast[p]                          = 1'b0;
          s_tid[p*TID_W +: TID_W]             = '0;
          s_tdest[p*TDEST_W +: TDEST_W]       = '0;
          s_tuser[p*TUSER_W +: TUSER_W]       = '0;
        end
      end
      s_tvalid = vld;
      m_tready = (int'($urandom_range(99)) < readyPct);
      @(negedge clk);
      fire = s_tvalid & s_tready;
    end
  end

  // Monitor: pops the expectation of the port named by tid on every master beat.
  initial begin
    bit           inPkt;
    int           curPort;
    int           p;
    bit           prevStall;
    logic [105:0] bus;
    logic [105:0] prevBus;
    logic [104:0] expBus;
    beat_t        e;
    inPkt = 1'b0; curPort = 0; prevStall = 1'b0; prevBus = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inPkt = 1'b0;
        prevStall = 1'b0;
      end else begin
        bus = {m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
        if (prevStall) checkOutput("stall hold", 128'(bus), 128'(prevBus));
        if (m_tvalid && m_tready) begin
          p = int'(m_tid);
          if (p >= NUM_IN || expQ[p % NUM_IN].size() == 0) begin
            checkOutput("beat has expectation", 128'(m_tid), 128'(255));
          end else begin
            e = expQ[p].pop_front();
            expBus = {e.data, e.strb, e.keep, e.last, e.tid, e.dest, e.user};
            checkOutput("beat payload", 128'(bus[104:0]), 128'(expBus));
          end
          if (!inPkt) begin
            startCyc.push_back(cyc);
            if (orderQ.size() > 0) checkOutput("packet order", 128'(p), 128'(orderQ.pop_front()));
            inPkt = 1'b1;
            curPort = p;
          end else begin
            checkOutput("no interleave", 128'(p), 128'(curPort));
          end
          if (m_tlast) inPkt = 1'b0;
        end
        prevStall = m_tvalid && !m_tready;
        prevBus = bus;
      end
    end
  end

  // Global safety net so the run can never hang.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed and random scenarios.
  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset m_tvalid", 128'(m_tvalid), 128'(0));
    checkOutput("reset busy", 128'(busy), 128'(0));
    checkOutput("reset grant_idx", 128'(grant_idx), 128'(0));
    checkOutput("reset s_tready", 128'(s_tready), 128'(0));
    checkOutput("reset m_tdata", 128'(m_tdata), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-packet: port 1 stalls behind m_tready=0, then reset hits.
    readyPct = 0;
    gapPct = 0;
    applyStimulus(1, 4, -1, 0, 1'b0, 64'h0);
    repeat (6) @(negedge clk);
    checkOutput("mid-packet busy", 128'(busy), 128'(1));
    checkOutput("mid-packet grant", 128'(grant_idx), 128'(1));
    checkOutput("mid-packet m_tvalid", 128'(m_tvalid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset m_tvalid", 128'(m_tvalid), 128'(0));
    checkOutput("async reset s_tready", 128'(s_tready), 128'(0));
    checkOutput("async reset busy", 128'(busy), 128'(0));
    flushReq++;
    for (int p = 0; p < NUM_IN; p++) expQ[p].delete();
    orderQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    readyPct = 100;
    applyStimulus(3, 2, -1, 0, 1'b0, 64'h0);
    applyStimulus(0, 2, -1, 0, 1'b0, 64'h0);
    orderQ.push_back(0);
    orderQ.push_back(3);
    waitDrain("drain after reset", 200);

    // Round robin with all ports requesting; 3 cycles per 2-beat packet.
    startCyc.delete();
    foreach (orderQ[i]) orderQ.delete(i);
    for (int p = 0; p < NUM_IN; p++) applyStimulus(p, 2, -1, 0, 1'b0, 64'h0);
    applyStimulus(0, 2, -1, 0, 1'b0, 64'h0);
    for (int p = 0; p < NUM_IN; p++) orderQ.push_back(p);
    orderQ.push_back(0);
    waitDrain("drain round robin", 200);
    checkOutput("rr packet count", 128'(startCyc.size()), 128'(5));
    for (int i = 1; i < startCyc.size(); i++) begin
      checkOutput("rr packet spacing", 128'(startCyc[i] - startCyc[i-1]), 128'(3));
    end

    // No interleave: port 0 pauses before beat 2 while port 1 waits.
    applyStimulus(0, 4, 2, 3, 1'b0, 64'h0);
    orderQ.push_back(0);
    orderQ.push_back(1);
    repeat (2) @(negedge clk);
    applyStimulus(1, 2, -1, 0, 1'b0, 64'h0);
    waitDrain("drain no interleave", 200);

    // Wrap: grant port 3, then ports 3 and 0 request together.
    applyStimulus(3, 3, -1, 0, 1'b0, 64'h0);
    orderQ.push_back(3);
    waitDrain("drain wrap setup", 200);
    applyStimulus(3, 2, -1, 0, 1'b0, 64'h0);
    applyStimulus(0, 2, -1, 0, 1'b0, 64'h0);
    orderQ.push_back(0);
    orderQ.push_back(3);
    waitDrain("drain wrap", 200);

    // Single-beat packets from port 2 only: one beat every 2 cycles.
    startCyc.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, 1, -1, 0, 1'b1, 64'hA5 + 64'(i));
      orderQ.push_back(2);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) checkOutput("single-beat grant_idx", 128'(grant_idx), 128'(2));
    end
    waitDrain("drain single-beat", 200);
    checkOutput("single-beat count", 128'(startCyc.size()), 128'(6));
    for (int i = 1; i < startCyc.size(); i++) begin
      checkOutput("single-beat spacing", 128'(startCyc[i] - startCyc[i-1]), 128'(2));
    end

    // Random traffic with backpressure and source gaps.
    readyPct = 50;
    gapPct = 30;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(int'($urandom_range(NUM_IN - 1)), int'($urandom_range(16, 1)), -1, 0, 1'b0, 64'h0);
    end
    waitDrain("drain random", 30000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
